alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/project_pkg.sv | 23 ++
 rtl/alu.sv | 30 +++
 rtl/alu_arbiter.sv | 103 ++++++++++
 tb/tb_alu_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/project_pkg.sv
// rtl/project_pkg.sv - shared word type, ALU opcodes and arbiter state encoding
package project_pkg;

    typedef logic [7:0] word;

    typedef enum logic [3:0] {
        ALU_NOP = 4'h0,
        ALU_ADD = 4'h1,
        ALU_SUB = 4'h2,
        ALU_AND = 4'h3,
        ALU_OR  = 4'h4,
        ALU_XOR = 4'h5,
        ALU_SLT = 4'h6,
        ALU_SLL = 4'h7,
        ALU_SRL = 4'h8
    } e_alu_op;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } e_arb_state;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 8-bit ALU; unknown opcodes produce 0
module alu
    import project_pkg::*;
(
    input  e_alu_op op,
    input  word     a,
    input  word     b,
    output word     result,
    output logic    zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            // Signed compare: 140 reads as -116
            ALU_SLT: result = {7'b0, $signed(a) < $signed(b)};
            ALU_SLL: result = a << b[2:0];
            ALU_SRL: result = a >> b[2:0];
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter with lock, sharing one ALU
module alu_arbiter
    import project_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic    [1:0] req_valid,
    output logic    [1:0] req_ready,
    input  e_alu_op [1:0] req_op,
    input  word     [1:0] req_a,
    input  word     [1:0] req_b,
    input  logic    [1:0] req_lock,
    output logic    [1:0] rsp_valid,
    input  logic    [1:0] rsp_ready,
    output word     [1:0] rsp_result,
    output logic    [1:0] rsp_zero
);

    e_arb_state state, state_nxt;
    logic       owner, owner_nxt;
    logic       prio;
    logic [1:0] eligible;
    logic [1:0] grant;
    logic       gnt_idx;
    e_alu_op    alu_op;
    word        alu_a, alu_b, alu_result;
    logic       alu_zero;

    // A port may only take a new operation if its result slot frees up this cycle
    always_comb begin
        eligible[0] = req_valid[0] & (~rsp_valid[0] | rsp_ready[0]) &
                      ((state == ARB_IDLE) | ~owner);
        eligible[1] = req_valid[1] & (~rsp_valid[1] | rsp_ready[1]) &
                      ((state == ARB_IDLE) | owner);
    end

    always_comb begin
        grant   = 2'b00;
        gnt_idx = 1'b0;
        if (!rst && eligible != 2'b00) begin
            gnt_idx        = (eligible == 2'b11) ? prio : eligible[1];
            grant[gnt_idx] = 1'b1;
        end
    end

    assign req_ready = grant;

    always_comb begin
        alu_op = ALU_NOP;
        alu_a  = '0;
        alu_b  = '0;
        if (grant != 2'b00) begin
            alu_op = req_op[gnt_idx];
            alu_a  = req_a[gnt_idx];
            alu_b  = req_b[gnt_idx];
        end
    end

    alu u_alu (
        .op     (alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Lock follows the lock bit of whichever transfer happens; in LOCKED only the owner transfers
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        if (grant != 2'b00) begin
            state_nxt = req_lock[gnt_idx] ? ARB_LOCKED : ARB_IDLE;
            if (req_lock[gnt_idx])
                owner_nxt = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= 1'b0;
            prio       <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_result <= '0;
            rsp_zero   <= 2'b00;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            if (grant != 2'b00)
                prio <= ~gnt_idx;
            for (int i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    rsp_valid[i]  <= 1'b1;
                    rsp_result[i] <= alu_result;
                    rsp_zero[i]   <= alu_zero;
                end else if (rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed vectors plus a per-cycle behavioural model of alu_arbiter
module tb_alu_arbiter;
    import project_pkg::*;

    logic          clk;
    logic          rst;
    logic    [1:0] req_valid;
    logic    [1:0] req_ready;
    e_alu_op [1:0] req_op;
    word     [1:0] req_a;
    word     [1:0] req_b;
    logic    [1:0] req_lock;
    logic    [1:0] rsp_valid;
    logic    [1:0] rsp_ready;
    word     [1:0] rsp_result;
    logic    [1:0] rsp_zero;

    int vectors     = 0;
    int miscompares = 0;

    alu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_lock   (req_lock),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int mdl_alu(input int op, input int a, input int b);
        int sa, sb, sh;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        sh = b % 8;
        case (op)
            1:       return (a + b) % 256;
            2:       return (a - b + 256) % 256;
            3:       return a & b;
            4:       return a | b;
            5:       return a ^ b;
            6:       return (sa < sb) ? 1 : 0;
            7:       return (a * (2 ** sh)) % 256;
            8:       return a / (2 ** sh);
            default: return 0;
        endcase
    endfunction

    // Model state describes the DUT as it should look after the upcoming rising edge
    bit m_live   = 1'b0;
    bit m_locked = 1'b0;
    int m_owner  = 0;
    int m_prio   = 0;
    bit m_rv[2];
    int m_res[2];
    bit m_zero[2];

    always @(negedge clk) begin
        bit ok[2];
        int win;
        int exp_rdy;
        if (rst) begin
            check("mdl_rdy_in_rst", req_ready, 0);
            m_live = 1'b1; m_locked = 1'b0; m_owner = 0; m_prio = 0;
            for (int i = 0; i < 2; i++) begin
                m_rv[i] = 1'b0; m_res[i] = 0; m_zero[i] = 1'b0;
            end
        end else if (m_live) begin
            for (int i = 0; i < 2; i++)
                ok[i] = req_valid[i] && (!m_rv[i] || rsp_ready[i]) && (!m_locked || m_owner == i);
            if (ok[0] && ok[1]) win = m_prio;
            else if (ok[0])     win = 0;
            else if (ok[1])     win = 1;
            else                win = -1;
            exp_rdy = (win < 0) ? 0 : (1 << win);
            check("mdl_req_ready", req_ready, exp_rdy);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("mdl_rsp_valid%0d", i), rsp_valid[i], m_rv[i]);
                check($sformatf("mdl_rsp_result%0d", i), rsp_result[i], m_res[i]);
                check($sformatf("mdl_rsp_zero%0d", i), rsp_zero[i], m_zero[i]);
            end
            for (int i = 0; i < 2; i++) begin
                if (win == i) begin
                    m_res[i]  = mdl_alu(int'(req_op[i]), int'(req_a[i]), int'(req_b[i]));
                    m_zero[i] = (m_res[i] == 0);
                    m_rv[i]   = 1'b1;
                end else if (m_rv[i] && rsp_ready[i]) begin
                    m_rv[i] = 1'b0;
                end
            end
            if (win >= 0) begin
                m_prio   = 1 - win;
                m_locked = req_lock[win];
                m_owner  = win;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] s5_valid [5] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b11};
    logic       s5_lock  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] s5_rdy   [5] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b10};

    initial begin
        rst = 1'b1; req_valid = 2'b11; req_lock = 2'b00; rsp_ready = 2'b11;
        req_op[0] = ALU_ADD; req_op[1] = ALU_ADD;
        req_a = '0; req_b = '0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 2'b00);
        step(); step();

        // Port0 ADD 120,100
        rst = 1'b0; req_valid = 2'b01;
        req_op[0] = ALU_ADD; req_a[0] = 8'd120; req_b[0] = 8'd100;
        @(negedge clk);
        check("s1_grant", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        @(negedge clk);
        check("s1_rsp_valid", rsp_valid, 2'b01);
        check("s1_result", rsp_result[0], 220);
        check("s1_zero", rsp_zero[0], 0);
        step();

        // Port1 SUB / SLT, then undefined op and wraparound on port0
        req_valid = 2'b10; req_op[1] = ALU_SUB; req_a[1] = 8'd5; req_b[1] = 8'd5;
        @(negedge clk);
        check("s2_grant", req_ready, 2'b10);
        step();
        req_op[1] = ALU_SLT; req_a[1] = 8'd120; req_b[1] = 8'd140;
        @(negedge clk);
        check("s2_sub_result", rsp_result[1], 0);
        check("s2_sub_zero", rsp_zero[1], 1);
        step();
        req_a[1] = 8'd140; req_b[1] = 8'd120;
        @(negedge clk);
        check("s2_slt_120_140", rsp_result[1], 0);
        step();
        req_valid = 2'b01; req_op[0] = e_alu_op'(4'hF); req_a[0] = 8'd3; req_b[0] = 8'd4;
        @(negedge clk);
        check("s2_slt_140_120", rsp_result[1], 1);
        check("s2_slt_zero", rsp_zero[1], 0);
        step();
        req_op[0] = ALU_ADD; req_a[0] = 8'd200; req_b[0] = 8'd100;
        @(negedge clk);
        check("s2_undef_result", rsp_result[0], 0);
        check("s2_undef_zero", rsp_zero[0], 1);
        step();
        req_valid = 2'b00;
        @(negedge clk);
        check("s2_wrap_result", rsp_result[0], 44);
        step();

        // Round-robin from reset with both ports streaming
        rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
        req_op[0] = ALU_ADD; req_a[0] = 8'd120; req_b[0] = 8'd100;
        req_op[1] = ALU_SUB; req_a[1] = 8'd50;  req_b[1] = 8'd8;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("s3_grant%0d", k), req_ready, (k % 2) ? 2'b10 : 2'b01);
            if (k > 0)
                check($sformatf("s3_latency%0d", k), rsp_valid, (k % 2) ? 2'b01 : 2'b10);
            step();
        end

        // Port0 result held unconsumed: port1 takes every slot
        rsp_ready = 2'b10;
        @(negedge clk);
        check("s4_first_grant", req_ready, 2'b01);
        step();
        for (int j = 0; j < 3; j++) begin
            req_a[1] = 8'(j + 1);
            @(negedge clk);
            check($sformatf("s4_grant%0d", j), req_ready, 2'b10);
            check($sformatf("s4_hold_valid%0d", j), rsp_valid[0], 1);
            check($sformatf("s4_hold_result%0d", j), rsp_result[0], 220);
            step();
        end

        // Port0 lock sequence, including an idle cycle while locked
        rsp_ready = 2'b11;
        for (int c = 0; c < 5; c++) begin
            req_valid   = s5_valid[c];
            req_lock[0] = s5_lock[c];
            @(negedge clk);
            check($sformatf("s5_grant%0d", c), req_ready, s5_rdy[c]);
            step();
        end

        // Reset while locked with both results pending
        rsp_ready = 2'b00; req_valid = 2'b11; req_lock = 2'b01;
        @(negedge clk);
        check("s6_lock_grant", req_ready, 2'b01);
        step();
        @(negedge clk);
        check("s6_both_pending", rsp_valid, 2'b11);
        check("s6_locked_block", req_ready, 2'b00);
        step();
        rst = 1'b1; rsp_ready = 2'b11;
        @(negedge clk);
        check("s6_rdy_in_rst", req_ready, 2'b00);
        step();
        rst = 1'b0; req_valid = 2'b10; rsp_ready = 2'b00; req_lock = 2'b00;
        @(negedge clk);
        check("s6_rsp_cleared", rsp_valid, 2'b00);
        check("s6_port1_grant", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
